// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared encodings and lane helpers for the MEM stage
package mem_stage_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  typedef enum logic {IDLE, BUSY} state_t;

  // Byte enables for an access, expressed on a 64-bit word; narrower banks use the low lanes.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] m;
    case (size)
      SZ_BYTE: m = 8'h01 << off;
      SZ_HALF: m = 8'h03 << off;
      SZ_WORD: m = 8'h0F << off;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  function automatic logic [63:0] load_extract(input logic [63:0] word, input logic [1:0] size,
                                               input logic [2:0] off, input logic sext);
    logic [63:0] sh;
    logic [63:0] r;
    sh = word >> {off, 3'b000};
    case (size)
      SZ_BYTE: r = {{56{sext & sh[7]}}, sh[7:0]};
      SZ_HALF: r = {{48{sext & sh[15]}}, sh[15:0]};
      SZ_WORD: r = {{32{sext & sh[31]}}, sh[31:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_bank.sv
// rtl/mem_bank.sv - single-port byte-enabled data RAM with combinational read
module mem_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [DATA_W/8-1:0]        be_i,
  input  logic [$clog2(DEPTH)-1:0]   addr_i,
  input  logic [DATA_W-1:0]          wdata_i,
  output logic [DATA_W-1:0]          rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage_pl.sv
// rtl/mem_stage_pl.sv - MEM pipeline stage: sized loads/stores, wait-state FSM, MEM/WB register
module mem_stage_pl
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 256,
  parameter int MEM_LAT = 0,
  parameter int REG_AW  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              Mem_R,
  input  logic              Mem_W,
  input  logic              WB,
  input  logic              RegW,
  input  logic [1:0]        Size,
  input  logic              Sign_Ext,
  input  logic [DATA_W-1:0] Alu_Res,
  input  logic [DATA_W-1:0] Data_in,
  input  logic [REG_AW-1:0] Rd2,
  output logic              stall,
  output logic              out_valid,
  output logic              RegW_out,
  output logic [DATA_W-1:0] WB_Data,
  output logic [REG_AW-1:0] Rd3,
  output logic              misalign
);

  localparam int NB    = DATA_W / 8;
  localparam int BO    = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              out_valid_q, regw_q, mis_q;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [REG_AW-1:0] rd3_q;

  logic              mem_op, mis, accept, stall_c, we;
  logic [2:0]        off3;
  logic [7:0]        mask8;
  logic [63:0]       din64, rep64, rd64, ld64;
  logic [DATA_W-1:0] rdata, ld_data;

  assign mem_op = Mem_R | Mem_W;

  always_comb begin
    off3 = '0;
    off3[BO-1:0] = Alu_Res[BO-1:0];
    case (Size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = off3[0];
      SZ_WORD: mis = |off3[1:0];
      default: mis = (DATA_W == 32) ? 1'b1 : |off3;
    endcase
    mis = mis & mem_op;
  end

  always_comb begin
    din64 = '0;
    din64[DATA_W-1:0] = Data_in;
    case (Size)
      SZ_BYTE: rep64 = {8{din64[7:0]}};
      SZ_HALF: rep64 = {4{din64[15:0]}};
      SZ_WORD: rep64 = {2{din64[31:0]}};
      default: rep64 = din64;
    endcase
    mask8 = lane_mask(Size, off3);
    rd64 = '0;
    rd64[DATA_W-1:0] = rdata;
    ld64 = load_extract(rd64, Size, off3, Sign_Ext);
    ld_data = ld64[DATA_W-1:0];
  end

  // Gated by rst so an access interrupted by reset can never commit a store.
  assign we = accept & Mem_W & ~mis & rst;

  mem_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank (
    .clk_i   (clk),
    .we_i    (we),
    .be_i    (mask8[NB-1:0]),
    .addr_i  (Alu_Res[BO +: IDX_W]),
    .wdata_i (rep64[DATA_W-1:0]),
    .rdata_o (rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!mem_op || MEM_LAT == 0) begin
            accept = 1'b1;
          end else begin
            stall_c = 1'b1;
            state_d = BUSY;
            cnt_d   = LAT_M1;
          end
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - 4'd1;
        end else begin
          accept  = in_valid;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if (mis)                 wb_data_d = '0;
    else if (mem_op && WB)   wb_data_d = Mem_W ? '0 : ld_data;
    else                     wb_data_d = Alu_Res;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      regw_q      <= 1'b0;
      mis_q       <= 1'b0;
      wb_data_q   <= '0;
      rd3_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= accept;
      if (accept) begin
        regw_q    <= RegW & ~mis;
        mis_q     <= mis;
        wb_data_q <= wb_data_d;
        rd3_q     <= Rd2;
      end
    end
  end

  assign stall     = stall_c & rst;
  assign out_valid = out_valid_q;
  assign RegW_out  = regw_q;
  assign misalign  = mis_q;
  assign WB_Data   = wb_data_q;
  assign Rd3       = rd3_q;

  logic unused_bits;
  assign unused_bits = ^{rep64, ld64, Alu_Res};

  assert property (@(posedge clk) disable iff (!rst) (state_q == BUSY) |-> in_valid);

endmodule

// File: tb/tb_mem_stage_pl.sv
// tb/tb_mem_stage_pl.sv - directed self-checking bench, MEM_LAT=0 and MEM_LAT=3 instances
module tb_mem_stage_pl;
  import mem_stage_pkg::*;

  logic        clk;
  logic        rst [2];
  logic        in_valid [2], mem_r [2], mem_w [2], wb [2], regw [2], sext [2];
  logic [1:0]  size [2];
  logic [31:0] alu [2], din [2];
  logic [4:0]  rd2 [2];
  logic        stall [2], out_valid [2], regw_out [2], mis [2];
  logic [31:0] wbd [2];
  logic [4:0]  rd3 [2];

  int n_chk  = 0;
  int n_pass = 0;

  logic        r_ov, r_mis, r_rw;
  logic [31:0] r_wbd;
  logic [4:0]  r_rd3;
  int          r_stalls, r_ovst;

  mem_stage_pl #(.DATA_W(32), .DEPTH(256), .MEM_LAT(0), .REG_AW(5)) u_dut_l0 (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .Mem_R(mem_r[0]), .Mem_W(mem_w[0]),
    .WB(wb[0]), .RegW(regw[0]), .Size(size[0]), .Sign_Ext(sext[0]), .Alu_Res(alu[0]),
    .Data_in(din[0]), .Rd2(rd2[0]), .stall(stall[0]), .out_valid(out_valid[0]),
    .RegW_out(regw_out[0]), .WB_Data(wbd[0]), .Rd3(rd3[0]), .misalign(mis[0])
  );

  mem_stage_pl #(.DATA_W(32), .DEPTH(256), .MEM_LAT(3), .REG_AW(5)) u_dut_l3 (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .Mem_R(mem_r[1]), .Mem_W(mem_w[1]),
    .WB(wb[1]), .RegW(regw[1]), .Size(size[1]), .Sign_Ext(sext[1]), .Alu_Res(alu[1]),
    .Data_in(din[1]), .Rd2(rd2[1]), .stall(stall[1]), .out_valid(out_valid[1]),
    .RegW_out(regw_out[1]), .WB_Data(wbd[1]), .Rd3(rd3[1]), .misalign(mis[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic op(input int d, input logic mr, input logic mw, input logic wbs, input logic rw,
                    input logic [1:0] sz, input logic sx, input logic [31:0] a,
                    input logic [31:0] dat, input logic [4:0] rd);
    @(negedge clk);
    mem_r[d] = mr; mem_w[d] = mw; wb[d] = wbs; regw[d] = rw; size[d] = sz;
    sext[d] = sx; alu[d] = a; din[d] = dat; rd2[d] = rd; in_valid[d] = 1'b1;
    r_stalls = 0;
    r_ovst   = 0;
    #1;
    while (stall[d] && r_stalls < 50) begin
      if (out_valid[d]) r_ovst++;
      r_stalls++;
      @(negedge clk);
      #1;
    end
    if (r_stalls >= 50) check("stall_timeout", 64'(r_stalls), 64'd0);
    @(negedge clk);
    r_ov = out_valid[d]; r_mis = mis[d]; r_rw = regw_out[d]; r_wbd = wbd[d]; r_rd3 = rd3[d];
    in_valid[d] = 1'b0;
  endtask

  task automatic st(input int d, input logic [1:0] sz, input logic [31:0] a,
                    input logic [31:0] dat, input logic [4:0] rd);
    op(d, 1'b0, 1'b1, 1'b0, 1'b0, sz, 1'b0, a, dat, rd);
  endtask

  task automatic ld(input int d, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                    input logic [4:0] rd);
    op(d, 1'b1, 1'b0, 1'b1, 1'b1, sz, sx, a, 32'h0, rd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; in_valid[d] = 1'b0; mem_r[d] = 1'b0; mem_w[d] = 1'b0; wb[d] = 1'b0;
      regw[d] = 1'b0; sext[d] = 1'b0; size[d] = SZ_WORD; alu[d] = '0; din[d] = '0; rd2[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_out_valid", out_valid[d], 1'b0);
      check("rst_stall", stall[d], 1'b0);
      check("rst_wb_data", wbd[d], 32'h0);
      rst[d] = 1'b1;
    end

    // 1: single-cycle store then load
    st(0, SZ_WORD, 32'd40, 32'd100, 5'd0);
    check("t1_sw_stalls", r_stalls, 0);
    check("t1_sw_valid", r_ov, 1'b1);
    ld(0, SZ_WORD, 1'b0, 32'd40, 5'd7);
    check("t1_lw_stalls", r_stalls, 0);
    check("t1_lw_data", r_wbd, 32'd100);
    check("t1_lw_rd3", r_rd3, 5'd7);
    check("t1_lw_regw", r_rw, 1'b1);
    check("t1_lw_valid", r_ov, 1'b1);
    @(negedge clk);
    check("t1_valid_drop", out_valid[0], 1'b0);

    // 2: three wait states
    st(1, SZ_WORD, 32'd20, 32'd200, 5'd0);
    check("t2_sw_stalls", r_stalls, 3);
    ld(1, SZ_WORD, 1'b0, 32'd20, 5'd3);
    check("t2_lw_stalls", r_stalls, 3);
    check("t2_valid_in_stall", r_ovst, 0);
    check("t2_lw_valid", r_ov, 1'b1);
    check("t2_lw_data", r_wbd, 32'd200);
    @(negedge clk);
    check("t2_valid_pulse", out_valid[1], 1'b0);

    // 3: byte lanes
    st(0, SZ_WORD, 32'h20, 32'h11223344, 5'd0);
    st(0, SZ_BYTE, 32'h21, 32'h000000AA, 5'd0);
    ld(0, SZ_BYTE, 1'b1, 32'h21, 5'd1);
    check("t3_lb", r_wbd, 32'hFFFFFFAA);
    ld(0, SZ_BYTE, 1'b0, 32'h21, 5'd1);
    check("t3_lbu", r_wbd, 32'h000000AA);
    ld(0, SZ_WORD, 1'b0, 32'h20, 5'd1);
    check("t3_lw", r_wbd, 32'h1122AA44);
    ld(0, SZ_HALF, 1'b0, 32'h22, 5'd1);
    check("t3_lhu_hi", r_wbd, 32'h00001122);

    // 4: misaligned accesses
    ld(0, SZ_HALF, 1'b1, 32'h23, 5'd6);
    check("t4_lh_mis", r_mis, 1'b1);
    check("t4_lh_regw", r_rw, 1'b0);
    check("t4_lh_data", r_wbd, 32'h0);
    check("t4_lh_valid", r_ov, 1'b1);
    st(0, SZ_WORD, 32'h22, 32'hDEADBEEF, 5'd0);
    check("t4_sw_mis", r_mis, 1'b1);
    ld(0, SZ_WORD, 1'b0, 32'h20, 5'd1);
    check("t4_ram_kept", r_wbd, 32'h1122AA44);
    check("t4_lw_mis_clr", r_mis, 1'b0);
    ld(1, SZ_WORD, 1'b0, 32'h22, 5'd2);
    check("t4_mis_lat_stalls", r_stalls, 3);
    check("t4_mis_lat_flag", r_mis, 1'b1);

    // 5: wrap, ALU pass-through, signed half, load+store collision
    st(0, SZ_WORD, 32'h400, 32'h5A5A5A5A, 5'd0);
    ld(0, SZ_WORD, 1'b0, 32'h0, 5'd1);
    check("t5_wrap", r_wbd, 32'h5A5A5A5A);
    op(0, 1'b0, 1'b0, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h1234, 32'h0, 5'd9);
    check("t5_alu_data", r_wbd, 32'h1234);
    check("t5_alu_rd3", r_rd3, 5'd9);
    check("t5_alu_regw", r_rw, 1'b1);
    op(1, 1'b0, 1'b0, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h55, 32'h0, 5'd9);
    check("t5_alu_nostall", r_stalls, 0);
    st(0, SZ_HALF, 32'h2, 32'h00008001, 5'd0);
    ld(0, SZ_HALF, 1'b1, 32'h2, 5'd1);
    check("t5_lh_sext", r_wbd, 32'hFFFF8001);
    ld(0, SZ_WORD, 1'b0, 32'h0, 5'd1);
    check("t5_sh_merge", r_wbd, 32'h80015A5A);
    op(0, 1'b1, 1'b1, 1'b1, 1'b1, SZ_WORD, 1'b0, 32'h40, 32'h77, 5'd4);
    check("t5_rw_wbdata", r_wbd, 32'h0);
    ld(0, SZ_WORD, 1'b0, 32'h40, 5'd1);
    check("t5_rw_stored", r_wbd, 32'h77);

    // 6: reset aborts a pending store
    st(1, SZ_WORD, 32'h30, 32'h0BADF00D, 5'd5);
    check("t6_pre_rd3", r_rd3, 5'd5);
    @(negedge clk);
    mem_r[1] = 1'b0; mem_w[1] = 1'b1; wb[1] = 1'b0; regw[1] = 1'b0; size[1] = SZ_WORD;
    alu[1] = 32'h30; din[1] = 32'h12345678; rd2[1] = 5'd8; in_valid[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("t6_busy_stall", stall[1], 1'b1);
    rst[1] = 1'b0;
    #1;
    check("t6_rst_stall", stall[1], 1'b0);
    check("t6_rst_valid", out_valid[1], 1'b0);
    check("t6_rst_wbd", wbd[1], 32'h0);
    check("t6_rst_rd3", rd3[1], 5'd0);
    check("t6_rst_regw", regw_out[1], 1'b0);
    check("t6_rst_mis", mis[1], 1'b0);
    in_valid[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b1;
    ld(1, SZ_WORD, 1'b0, 32'h30, 5'd2);
    check("t6_store_dropped", r_wbd, 32'h0BADF00D);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
